// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch sequencer with prefetch FIFO, redirect flush and halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0] buf_pc [DEPTH];
  logic [31:0] buf_instr [DEPTH];
  logic pop, push, flush, unused;
  assign pop = instr_valid && instr_ready;
  assign flush = redirect && state != BOOT;
  assign push = state == RUN && !redirect && !halt && (count != FULL || pop);
  assign imem_addr = fetch_pc;
  assign instr_valid = count != '0;
  assign instr = buf_instr[rd_ptr];
  assign instr_pc = buf_pc[rd_ptr];
  assign halted = state == HALTED && count == '0;
  assign unused = ^redirect_pc[1:0];
  // BOOT always enters RUN; otherwise halt without redirect parks in HALTED
  always_comb state_n = (state != BOOT && !redirect && halt) ? HALTED : RUN;
  // state, PC, pointers and occupancy; redirect flushes after any same-cycle pop
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        fetch_pc <= push ? fetch_pc + 32'd4 : fetch_pc;
        wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  // FIFO storage; contents are qualified by count so need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr] <= fetch_pc;
      buf_instr[wr_ptr] <= imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0, reset = 1, redirect = 0, halt = 0, instr_ready = 1;
  logic [31:0] redirect_pc = 0, imem_data, imem_addr, instr, instr_pc;
  logic instr_valid, halted;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_q [$];
  logic [31:0] seen [$];
  logic [31:0] m_pc = 0, frozen;
  int m_st = 0;
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .halted(halted)
  );
  always #5 clk = ~clk;
  assign imem_data = 32'h1000_0000 + (imem_addr >> 2);
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction
  function automatic logic [31:0] seen_at(input int i);
    return seen.size() > i ? seen[i] : 32'hDEAD_BEEF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    bit pop, push;
    if (instr_valid && instr_ready) seen.push_back(instr_pc);
    @(posedge clk);
    if (reset) begin
      m_st = 0;
      m_pc = 0;
      exp_q.delete();
    end else begin
      pop = exp_q.size() != 0 && instr_ready;
      push = m_st == 1 && !redirect && !halt && (exp_q.size() < 2 || pop);
      if (pop) void'(exp_q.pop_front());
      if (redirect && m_st != 0) begin
        exp_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        exp_q.push_back({m_pc, word(m_pc)});
        m_pc = m_pc + 4;
      end
      case (m_st)
        0: m_st = 1;
        1: if (!redirect && halt) m_st = 2;
        default: if (redirect || !halt) m_st = 1;
      endcase
    end
    #1;
    chk("valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
    chk("halted", {31'b0, halted}, {31'b0, m_st == 2 && exp_q.size() == 0});
    chk("imem_addr", imem_addr, m_pc);
    if (exp_q.size() != 0) begin
      chk("instr_pc", instr_pc, exp_q[0][63:32]);
      chk("instr", instr, exp_q[0][31:0]);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_addr", imem_addr, 0);
    tick();
    chk("boot_valid", {31'b0, instr_valid}, 0);
    tick();
    chk("first_pc", instr_pc, 0);
    chk("first_instr", instr, 32'h1000_0000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", instr_pc, 32'(4 * i));
      chk("seq_instr", instr, 32'h1000_0000 + 32'(i));
    end
    do_reset();
    tick();
    tick();
    instr_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_addr", imem_addr, 8);
    chk("bp_head", instr_pc, 0);
    instr_ready = 1;
    seen.delete();
    for (int i = 0; i < 3; i++) tick();
    chk("bp_d0", seen_at(0), 0);
    chk("bp_d1", seen_at(1), 4);
    chk("bp_d2", seen_at(2), 8);
    for (int i = 0; i < 20 && instr_pc != 32'h10; i++) tick();
    chk("reach_10", instr_pc, 32'h10);
    seen.delete();
    redirect = 1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect = 0;
    chk("rd_flush", {31'b0, instr_valid}, 0);
    tick();
    chk("rd_valid", {31'b0, instr_valid}, 1);
    chk("rd_pc", instr_pc, 32'h40);
    tick();
    tick();
    chk("rd_s0", seen_at(0), 32'h10);
    chk("rd_s1", seen_at(1), 32'h40);
    chk("rd_s2", seen_at(2), 32'h44);
    frozen = imem_addr;
    halt = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("halt_halted", {31'b0, halted}, 1);
    chk("halt_addr", imem_addr, frozen);
    halt = 0;
    seen.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("resume_pc", seen_at(0), frozen);
    chk("resume_next", seen_at(1), frozen + 4);
    redirect = 1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 0;
    seen.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("wrap0", seen_at(0), 32'hFFFF_FFF8);
    chk("wrap1", seen_at(1), 32'hFFFF_FFFC);
    chk("wrap2", seen_at(2), 32'h0000_0000);
    instr_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1;
    redirect = 1;
    redirect_pc = 32'h0000_0080;
    tick();
    reset = 0;
    chk("mrst_valid", {31'b0, instr_valid}, 0);
    chk("mrst_addr", imem_addr, 0);
    tick();
    redirect = 0;
    instr_ready = 1;
    tick();
    chk("mrst_pc", instr_pc, 0);
    chk("mrst_v", {31'b0, instr_valid}, 1);
    tick();
    chk("mrst_next", instr_pc, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the RV32 core. It owns the program counter and drives the byte address of the instruction memory, which returns the word combinationally. It captures each fetched word together with its PC into a small prefetch FIFO and hands them to decode over a valid/ready handshake. It also handles control-flow redirects (branch/jump/trap) with a flush, and halt requests.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset
- `DEPTH`, 2, prefetch FIFO entries; power of two, ≥2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `imem_addr`  out  32  byte address to instruction memory; always equals `fetch_pc`
- `imem_data`  in  32  instruction word at `imem_addr`, valid in the same cycle (combinational read)
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (treated as 0)
- `halt`  in  1  level: stop issuing new fetches while high
- `instr_valid`  out  1  FIFO head holds a valid instruction
- `instr_ready`  in  1  decode accepts head this cycle
- `instr`  out  32  instruction word at FIFO head
- `instr_pc`  out  32  PC of `instr`
- `halted`  out  1  high in HALTED state with FIFO empty

## Operation
- State register: BOOT, RUN, HALTED.
- Reset (sampled high at an edge): state=BOOT, `fetch_pc`=RESET_PC, FIFO count=0, rd/wr pointers=0. Outputs are then `instr_valid`=0, `halted`=0, and `imem_addr`=RESET_PC. `instr`/`instr_pc` are don't-care while invalid.
- BOOT -> RUN at the first edge with `reset` low. No push happens in BOOT.
- Pop: `instr_valid && instr_ready`. Removes the head.
- Push (RUN only): `!redirect && !halt && (count<DEPTH || pop)`. Writes {`fetch_pc`, `imem_data`} at the tail and sets `fetch_pc` += 4, with 32-bit wrap (FFFF_FFFC -> 0000_0000).
- Simultaneous push and pop when full is legal: count is unchanged.
- Redirect (any state except BOOT) has priority over push and halt:
  - A pop in the same cycle still completes (it is the redirecting instruction).
  - All remaining entries are flushed: count=0, pointers reset.
  - `fetch_pc` = {`redirect_pc`[31:2], 2'b00}.
  - From HALTED, redirect returns to RUN.
- Redirect during BOOT is ignored.
- RUN -> HALTED when `halt`=1 and no redirect. No push occurs in that cycle; the FIFO keeps draining through pops.
- HALTED -> RUN when `halt`=0.
- `halted` = (state==HALTED) && count==0.
- `instr_valid` = count!=0. It is never masked by `redirect`, so there is no combinational path from `redirect` to `instr_valid`.
- `instr`, `instr_pc`, `instr_valid` are registered/FIFO outputs, with no path from `imem_data`.

## Timing
- First instruction: `instr_valid` rises after the 2nd rising edge with `reset` low (BOOT edge, then push edge), with `instr_pc`=RESET_PC.
- Steady state with `instr_ready`=1: one instruction per cycle, PCs consecutive (+4).
- Redirect latency: with `redirect` at edge N, `instr_valid`=0 between N and N+1. Push of `redirect_pc` happens at N+1, so it is at the head after N+1.
- Backpressure: with `instr_ready`=0, the FIFO fills in DEPTH push cycles. `fetch_pc` then holds, and `imem_addr` stays stable until a slot frees.
- Halt: the last push happens at the edge before `halt` is sampled high. `halted` rises the cycle after the final pop.
- `reset` mid-operation: takes effect at the next edge regardless of `redirect`/`halt`/handshake, and discards the FIFO contents.

## Test plan
- Reset release, memory word i = 0x1000_0000+i, `instr_ready`=1:
  - `instr_valid` high after 2nd edge, `instr_pc`=0/`instr`=0x1000_0000.
  - Next cycles: PC 4, 8, 12 with matching words, one per cycle.
- `instr_ready`=0 for 5 cycles after the first valid:
  - Count saturates at 2 and `imem_addr` holds at 8.
  - On releasing ready: PCs 0, 4, 8 delivered in order, with no duplicates or skips.
- `redirect`=1, `redirect_pc`=0x0000_0043, while the head PC=0x10 is popped:
  - Pop of 0x10 is accepted.
  - Next valid `instr_pc`=0x40 one edge later; entry 0x14 never appears.
- `halt` high for 4 cycles with `instr_ready`=1:
  - FIFO drains, `halted`=1, and `imem_addr` is frozen.
  - On `halt` low, fetch resumes at the next sequential PC.
- `redirect_pc`=0xFFFF_FFF8 → delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `reset` asserted for one cycle while the FIFO is full and `redirect` is high:
  - After reset: count=0, `instr_valid`=0.
  - Restart at RESET_PC; the redirect target is ignored.
